// File: rtl/vga_text_fetch.sv
// vga_text_fetch -- text-row prefetch into a ping-pong character line buffer.
//
// Once per text row the FETCH state reads that row's character codes from
// SDRAM, one byte per request, into the bank that is not being displayed.
// The pixel stage reads the displayed bank by column with one cycle of
// latency. A row_swap exchanges the banks; a swap that arrives while a
// fetch is still running aborts that fetch (underrun).
//
// Optional feature macro: VGA_FETCH_UNDERRUN_EN
//   defined   : per-bank valid bits, sticky underrun_out, and reads from an
//               invalid displayed bank return 8'h20 (space)
//   undefined : no valid bits, underrun_out tied 0, raw buffer reads
//
// Ports
//   clk_in        pixel clock (rising edge)
//   rst_n         asynchronous active-low reset
//   mode_config   bit0: 40-column mode, else 80 columns
//   fetch_start   pulse: start filling the inactive bank with fetch_row
//   fetch_row     text row to fetch, sampled with fetch_start
//   row_swap      pulse: toggle the displayed bank
//   char_col_in   column to read from the displayed bank
//   char_out      registered character code for char_col_in
//   mem_req       SDRAM read request, held until mem_ack
//   mem_addr      byte address of the current request
//   mem_ack       pulse: mem_data valid
//   mem_data      SDRAM read data
//   fetch_busy    high while fetching
//   fetch_done    pulse after the last byte of a row is written
//   underrun_out  sticky underrun flag
module vga_text_fetch #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int          MAX_COLS  = 80
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [8:0]  mode_config,
  input  logic        fetch_start,
  input  logic [5:0]  fetch_row,
  input  logic        row_swap,
  input  logic [6:0]  char_col_in,
  output logic [7:0]  char_out,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        underrun_out
);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t      state;
  logic        disp_sel;   // displayed bank
  logic        fill_bank;  // bank being filled by the current fetch
  logic [6:0]  cols;
  logic [6:0]  idx;

  logic [7:0]  bank0 [MAX_COLS];
  logic [7:0]  bank1 [MAX_COLS];

  logic [6:0]  cols_new;
  logic [12:0] row_off;
  logic [23:0] base_new;
  logic        tgt_bank;
  logic        last_byte;
  logic        wr_en;

  logic unused_mode;
  assign unused_mode = ^mode_config[8:1];

  assign cols_new  = mode_config[0] ? 7'd40 : 7'd80;
  assign row_off   = 13'(fetch_row) * 13'(cols_new);
  assign base_new  = BASE_ADDR + {11'd0, row_off};
  // A swap in the same cycle lands first, so the new fetch targets the
  // bank that was displayed until now.
  assign tgt_bank  = row_swap ? disp_sel : ~disp_sel;
  assign last_byte = (idx == cols - 7'd1);
  // A swap in FETCH aborts; an ack in that same cycle is dropped.
  assign wr_en     = (state == S_FETCH) && mem_ack && !row_swap;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      disp_sel   <= 1'b0;
      fill_bank  <= 1'b1;
      cols       <= 7'd80;
      idx        <= 7'd0;
      mem_req    <= 1'b0;
      mem_addr   <= 24'd0;
      fetch_busy <= 1'b0;
      fetch_done <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      if (row_swap) disp_sel <= ~disp_sel;
      case (state)
        S_IDLE: begin
          if (fetch_start) begin
            state      <= S_FETCH;
            cols       <= cols_new;
            idx        <= 7'd0;
            mem_addr   <= base_new;
            fill_bank  <= tgt_bank;
            mem_req    <= 1'b1;
            fetch_busy <= 1'b1;
          end
        end
        S_FETCH: begin
          if (row_swap) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            fetch_busy <= 1'b0;
          end else if (mem_ack) begin
            if (last_byte) begin
              state      <= S_IDLE;
              mem_req    <= 1'b0;
              fetch_busy <= 1'b0;
              fetch_done <= 1'b1;
            end else begin
              idx      <= idx + 7'd1;
              mem_addr <= mem_addr + 24'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line buffer write port; contents are not reset.
  always_ff @(posedge clk_in) begin
    if (wr_en && (int'(idx) < MAX_COLS)) begin
      if (fill_bank) bank1[idx] <= mem_data;
      else           bank0[idx] <= mem_data;
    end
  end

`ifdef VGA_FETCH_UNDERRUN_EN
  logic [1:0] bank_vld;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bank_vld     <= 2'b00;
      underrun_out <= 1'b0;
    end else begin
      if (state == S_IDLE && fetch_start) bank_vld[tgt_bank] <= 1'b0;
      if (wr_en && last_byte)             bank_vld[fill_bank] <= 1'b1;
      if (state == S_FETCH && row_swap)   underrun_out <= 1'b1;
    end
  end
`else
  assign underrun_out = 1'b0;
`endif

  // Read port: one-cycle latency, out-of-range columns read as 8'h00.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      char_out <= 8'h00;
    end else if (int'(char_col_in) < MAX_COLS) begin
`ifdef VGA_FETCH_UNDERRUN_EN
      if (!bank_vld[disp_sel]) char_out <= 8'h20;
      else
`endif
      char_out <= disp_sel ? bank1[char_col_in] : bank0[char_col_in];
    end else begin
      char_out <= 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Directed bench for vga_text_fetch (BASE_ADDR = 24'hFFF000).
// A responder returns mem_data = mem_addr[7:0] after ack_dly wait cycles
// and logs every acknowledged address.
module tb_vga_text_fetch;
`ifdef VGA_FETCH_UNDERRUN_EN
  localparam bit UR = 1'b1;
`else
  localparam bit UR = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [8:0]  mode_config;
  logic        fetch_start;
  logic [5:0]  fetch_row;
  logic        row_swap;
  logic [6:0]  char_col_in;
  logic [7:0]  char_out;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        fetch_busy;
  logic        fetch_done;
  logic        underrun_out;

  vga_text_fetch #(.BASE_ADDR(24'hFFF000), .MAX_COLS(80)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .mode_config(mode_config),
    .fetch_start(fetch_start), .fetch_row(fetch_row), .row_swap(row_swap),
    .char_col_in(char_col_in), .char_out(char_out), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .underrun_out(underrun_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;
  int ack_dly = 0;
  int done_cnt = 0;
  int stable_bad = 0;
  logic [23:0] addr_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  // SDRAM responder
  initial begin
    int wait_cnt;
    logic [23:0] hold;
    wait_cnt = 0;
    hold = '0;
    mem_ack = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(negedge clk_in);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt == 0) hold = mem_addr;
        else if (mem_addr !== hold) stable_bad++;
        if (wait_cnt >= ack_dly) begin
          mem_ack  = 1'b1;
          mem_data = mem_addr[7:0];
          addr_q.push_back(mem_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk_in) if (fetch_done === 1'b1) done_cnt++;

  task automatic start(input logic [5:0] row, input logic m40, input logic swp);
    fetch_row = row;
    mode_config = {8'h00, m40};
    fetch_start = 1'b1;
    row_swap = swp;
    tick();
    fetch_start = 1'b0;
    row_swap = 1'b0;
  endtask

  task automatic swap();
    row_swap = 1'b1;
    tick();
    row_swap = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      tick();
      if (fetch_done === 1'b1) begin
        seen = 1;
        chk("done_req_low", {31'd0, mem_req}, 0);
        chk("done_busy_low", {31'd0, fetch_busy}, 0);
      end
    end
    chk("done_seen", {31'd0, seen}, 1);
  endtask

  task automatic chk_addrs(input string tag, input logic [23:0] first, input int cnt);
    int bad;
    bad = 0;
    for (int k = 0; k < addr_q.size(); k++)
      if (addr_q[k] !== first + 24'(k)) bad++;
    chk({tag, "_count"}, addr_q.size(), cnt);
    chk({tag, "_seq"}, bad, 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    mode_config = '0;
    fetch_start = 1'b0;
    fetch_row = '0;
    row_swap = 1'b0;
    char_col_in = 7'd5;
    tick(2);
    chk("rst_req", {31'd0, mem_req}, 0);
    chk("rst_addr", {8'd0, mem_addr}, 0);
    chk("rst_char", {24'd0, char_out}, 0);
    chk("rst_busy", {31'd0, fetch_busy}, 0);
    chk("rst_done", {31'd0, fetch_done}, 0);
    chk("rst_underrun", {31'd0, underrun_out}, 0);
    rst_n = 1'b1;
    tick(2);

    // 40-col row 3: base FFF000 + 120 = FFF078; mid-fetch restart and
    // mode change must be ignored.
    addr_q.delete();
    d0 = done_cnt;
    start(6'd3, 1'b1, 1'b0);
    chk("a_req", {31'd0, mem_req}, 1);
    chk("a_busy", {31'd0, fetch_busy}, 1);
    chk("a_addr0", {8'd0, mem_addr}, 32'hFFF078);
    tick(4);
    start(6'd10, 1'b0, 1'b0);
    wait_done(200);
    tick(3);
    chk_addrs("a_addr", 24'hFFF078, 40);
    chk("a_done_once", done_cnt - d0, 1);
    swap();
    tick();
    chk("a_col5", {24'd0, char_out}, 32'h7D);
    char_col_in = 7'd39;
    tick();
    chk("a_col39", {24'd0, char_out}, 32'h9F);
    char_col_in = 7'd100;
    tick();
    chk("col100", {24'd0, char_out}, 0);
    char_col_in = 7'd5;

    // 80-col row 63, 3-cycle ack delay: 5040 = 0x13B0, FFF000+13B0 wraps to 0003B0.
    addr_q.delete();
    stable_bad = 0;
    ack_dly = 3;
    start(6'd63, 1'b0, 1'b0);
    chk("b_addr0", {8'd0, mem_addr}, 32'h0003B0);
    wait_done(600);
    chk_addrs("b_addr", 24'h0003B0, 80);
    chk("b_addr_stable", stable_bad, 0);
    chk("b_last", {8'd0, addr_q[$]}, 32'h0003FF);
    chk("b_disp_kept", {24'd0, char_out}, 32'h7D);

    // Swap + start together: displayed bank flips, fetch refills the old one.
    ack_dly = 0;
    addr_q.delete();
    start(6'd0, 1'b1, 1'b1);
    chk("c_old_read", {24'd0, char_out}, 32'h7D);
    tick();
    chk("c_new_read", {24'd0, char_out}, 32'hB5);
    wait_done(200);
    chk_addrs("c_addr", 24'hFFF000, 40);
    tick();
    chk("c_bank_untouched", {24'd0, char_out}, 32'hB5);
    swap();
    tick();
    chk("c_filled_bank", {24'd0, char_out}, 32'h05);

    // Underrun: swap mid-fetch of an 80-col row.
    addr_q.delete();
    d0 = done_cnt;
    start(6'd0, 1'b0, 1'b0);
    tick(10);
    row_swap = 1'b1;
    tick();
    row_swap = 1'b0;
    chk("u_req_drop", {31'd0, mem_req}, 0);
    chk("u_busy_drop", {31'd0, fetch_busy}, 0);
    chk("u_flag", {31'd0, underrun_out}, {31'd0, UR});
    tick(20);
    chk("u_no_done", done_cnt - d0, 0);
    chk("u_read", {24'd0, char_out}, UR ? 32'h20 : 32'h05);
    start(6'd1, 1'b1, 1'b0);
    wait_done(200);
    tick();
    chk("u_read_pre_swap", {24'd0, char_out}, UR ? 32'h20 : 32'h05);
    swap();
    tick();
    chk("u_read_after", {24'd0, char_out}, 32'h2D);
    chk("u_sticky", {31'd0, underrun_out}, {31'd0, UR});

    // Reset mid-fetch.
    ack_dly = 3;
    start(6'd2, 1'b0, 1'b0);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    chk("r_req", {31'd0, mem_req}, 0);
    chk("r_busy", {31'd0, fetch_busy}, 0);
    chk("r_char", {24'd0, char_out}, 0);
    chk("r_underrun", {31'd0, underrun_out}, 0);
    tick(2);
    rst_n = 1'b1;
    addr_q.delete();
    tick(10);
    chk("r_no_reissue", addr_q.size(), 0);
    chk("r_req_idle", {31'd0, mem_req}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end
endmodule
